arch_rat: RTL and testbench
===========================

// Module: arch_rat
// PURPOSE
//  Architectural (committed) register alias table for the 4-wide rename stage.
//  - Updated at retire from the ROB: up to 4 committed arch->phys mappings per cycle.
//  - Returns each displaced physical register to the free list.
//  - On a branch-mispredict flush, drives the full committed map to the speculative
//    RAT as a one-cycle recovery pulse, then stalls rename for a programmable hold.
// PARAMETERS
//  NUM_AREG  32  architectural registers (r31 = hardwired zero, never remapped)
//  PREG_W    7   physical register tag width
//  REC_HOLD  1   stall cycles held after the recovery pulse (>=1)
// PORTS
//  clock              in   1              single clock
//  reset              in   1              synchronous, active-high
//  instN_ret_we_i     in   1              N=0..3: slot N retires with a dest write; slot 0 oldest
//  instN_ard_i        in   5              N=0..3: retiring arch dest
//  instN_prd_i        in   PREG_W         N=0..3: committed phys dest
//  flush_req_i        in   1              mispredict flush, sampled in IDLE only
//  instN_free_vld_o   out  1              N=0..3: displaced phys reg valid
//  instN_free_prd_o   out  PREG_W         N=0..3: displaced phys reg, to free list
//  arch_rat_rec_o     out  1              recovery pulse to speculative RAT
//  arch_rat_rec_data_o out NUM_AREG*PREG_W full map; entry i at [i*PREG_W +: PREG_W]
//  arch_stall_o       out  1              rename stall during recovery
// BEHAVIOUR
//  - Reset: table[i]=i; rec_data_o=identity; rec_o=0; stall_o=0; free_vld=0; free_prd=0; FSM=IDLE.
//    Reset overrides everything, including mid-recovery.
//  - Retire: slots commit in program order 0->3.
//    - Old mapping for slot k = table forwarded through the enabled slots <k with the same ard.
//    - Final table[ard] = youngest enabled writer (highest slot).
//  - Write with ard==31: no table update, free_vld=0 for that slot, no forwarding effect.
//  - Free outputs are registered, latency 1: a retire in cycle T gives free_vld/free_prd in T+1.
//    free_vld is 0 in any slot not retiring.
//  - rec_data_o is the registered table (post-update), continuously driven. Qualify it with rec_o.
//  - FSM states: IDLE, RECOVER, HOLD.
//    - IDLE: flush_req_i=1 in cycle T -> RECOVER at T+1. Retires presented in T are committed
//      first (they are older than the flush).
//    - RECOVER: exactly 1 cycle; rec_o=1, stall_o=1; rec_data_o includes the T retires. Then HOLD.
//    - HOLD: REC_HOLD cycles with stall_o=1, rec_o=0. Then IDLE.
//  - stall_o = (state != IDLE). stall_o is 0 during cycle T itself.
//  - In RECOVER/HOLD: flush_req_i is ignored (coalesced). Retire inputs must be 0; they are
//    ignored and must not update the table, and a sim assertion fires if any are seen.
//  - Flush and retire in the same IDLE cycle are both honoured. There are no other hazards.
// TESTING
//  1. Assert reset 2 cycles, release -> rec_data_o[i*7+:7]==i for all i; all outputs 0; stall_o 0.
//  2. Slot0 retire r3->p40 -> next cycle free_vld0=1, free_prd0=3; table[3]=40.
//  3. Same cycle: slot0 r5->p33, slot2 r5->p34, slot3 r6->p35 ->
//     free_prd0=5, free_prd2=33, free_prd3=6; table[5]=34, table[6]=35.
//  4. IDLE, flush_req=1 with slot1 r7->p50 in cycle T ->
//     T+1: rec_o=1, rec_data_o[55:49]=50, stall_o=1;
//     T+2 (REC_HOLD=1): rec_o=0, stall_o=1; T+3: stall_o=0.
//  5. Retire r31->p60 on slot0 -> free_vld0=0; table[31]=31 unchanged.
//     Then flush_req re-asserted during HOLD -> no second rec_o pulse.
//  6. reset asserted during HOLD after a remap r2->p70 ->
//     next cycle stall_o=0, rec_o=0, table[2]=2, FSM IDLE.

Source files
------------

// File: rtl/arch_rat_if.sv
// Retire/recovery bundle between the ROB retire port, the committed RAT, and its consumers
// (free list, speculative RAT, rename stall).
interface arch_rat_if #(
  parameter int NUM_AREG = 32,
  parameter int PREG_W   = 7
);
  logic                       inst0_ret_we_i;
  logic                       inst1_ret_we_i;
  logic                       inst2_ret_we_i;
  logic                       inst3_ret_we_i;
  logic [4:0]                 inst0_ard_i;
  logic [4:0]                 inst1_ard_i;
  logic [4:0]                 inst2_ard_i;
  logic [4:0]                 inst3_ard_i;
  logic [PREG_W-1:0]          inst0_prd_i;
  logic [PREG_W-1:0]          inst1_prd_i;
  logic [PREG_W-1:0]          inst2_prd_i;
  logic [PREG_W-1:0]          inst3_prd_i;
  logic                       flush_req_i;
  logic                       inst0_free_vld_o;
  logic                       inst1_free_vld_o;
  logic                       inst2_free_vld_o;
  logic                       inst3_free_vld_o;
  logic [PREG_W-1:0]          inst0_free_prd_o;
  logic [PREG_W-1:0]          inst1_free_prd_o;
  logic [PREG_W-1:0]          inst2_free_prd_o;
  logic [PREG_W-1:0]          inst3_free_prd_o;
  logic                       arch_rat_rec_o;
  logic [NUM_AREG*PREG_W-1:0] arch_rat_rec_data_o;
  logic                       arch_stall_o;

  modport master (
    output inst0_ret_we_i, inst1_ret_we_i, inst2_ret_we_i, inst3_ret_we_i,
    output inst0_ard_i, inst1_ard_i, inst2_ard_i, inst3_ard_i,
    output inst0_prd_i, inst1_prd_i, inst2_prd_i, inst3_prd_i,
    output flush_req_i,
    input  inst0_free_vld_o, inst1_free_vld_o, inst2_free_vld_o, inst3_free_vld_o,
    input  inst0_free_prd_o, inst1_free_prd_o, inst2_free_prd_o, inst3_free_prd_o,
    input  arch_rat_rec_o, arch_rat_rec_data_o, arch_stall_o
  );

  modport slave (
    input  inst0_ret_we_i, inst1_ret_we_i, inst2_ret_we_i, inst3_ret_we_i,
    input  inst0_ard_i, inst1_ard_i, inst2_ard_i, inst3_ard_i,
    input  inst0_prd_i, inst1_prd_i, inst2_prd_i, inst3_prd_i,
    input  flush_req_i,
    output inst0_free_vld_o, inst1_free_vld_o, inst2_free_vld_o, inst3_free_vld_o,
    output inst0_free_prd_o, inst1_free_prd_o, inst2_free_prd_o, inst3_free_prd_o,
    output arch_rat_rec_o, arch_rat_rec_data_o, arch_stall_o
  );
endinterface

// File: rtl/arch_rat.sv
// Committed RAT: 4-wide in-order retire update, freed tags out 1 cycle later, flush drives
// a one-cycle recovery pulse then stalls rename for REC_HOLD cycles; no backpressure accepted.
module arch_rat #(
  parameter int NUM_AREG = 32,
  parameter int PREG_W   = 7,
  parameter int REC_HOLD = 1
) (
  input logic       clock,
  input logic       reset,
  arch_rat_if.slave rat
);
  localparam int CW = $clog2(REC_HOLD + 1);

  typedef enum logic [1:0] {IDLE, RECOVER, HOLD} state_t;

  state_t            state_q;
  logic [CW-1:0]     hold_cnt;
  logic              rec_q;
  logic              stall_q;
  logic [PREG_W-1:0] tbl_q   [NUM_AREG];
  logic [PREG_W-1:0] tbl_n   [NUM_AREG];
  logic [3:0]        free_vld_q;
  logic [PREG_W-1:0] free_prd_q [4];

  logic [3:0]        we;
  logic [4:0]        ard     [4];
  logic [PREG_W-1:0] prd     [4];
  logic [3:0]        eff;
  logic [PREG_W-1:0] old_prd [4];

  assign we     = {rat.inst3_ret_we_i, rat.inst2_ret_we_i, rat.inst1_ret_we_i, rat.inst0_ret_we_i};
  assign ard[0] = rat.inst0_ard_i;
  assign ard[1] = rat.inst1_ard_i;
  assign ard[2] = rat.inst2_ard_i;
  assign ard[3] = rat.inst3_ard_i;
  assign prd[0] = rat.inst0_prd_i;
  assign prd[1] = rat.inst1_prd_i;
  assign prd[2] = rat.inst2_prd_i;
  assign prd[3] = rat.inst3_prd_i;

  // Older slots writing the same arch reg displace the table entry before younger ones see it.
  always_comb begin
    tbl_n = tbl_q;
    for (int k = 0; k < 4; k++) begin
      eff[k]     = we[k] && (ard[k] != 5'd31) && (state_q == IDLE);
      old_prd[k] = tbl_q[ard[k]];
    end
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < k; j++) begin
        if (eff[j] && (ard[j] == ard[k])) old_prd[k] = prd[j];
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (eff[k]) tbl_n[ard[k]] = prd[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) tbl_q[i] <= PREG_W'(i);
      for (int k = 0; k < 4; k++) free_prd_q[k] <= '0;
      free_vld_q <= '0;
      state_q    <= IDLE;
      hold_cnt   <= '0;
      rec_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      tbl_q      <= tbl_n;
      free_vld_q <= eff;
      for (int k = 0; k < 4; k++) free_prd_q[k] <= eff[k] ? old_prd[k] : '0;
      case (state_q)
        IDLE: begin
          if (rat.flush_req_i) begin
            state_q <= RECOVER;
            rec_q   <= 1'b1;
            stall_q <= 1'b1;
          end
        end
        RECOVER: begin
          state_q  <= HOLD;
          rec_q    <= 1'b0;
          stall_q  <= 1'b1;
          hold_cnt <= CW'(REC_HOLD - 1);
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          rec_q   <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_AREG; g++) begin : g_rec
    assign rat.arch_rat_rec_data_o[g*PREG_W +: PREG_W] = tbl_q[g];
  end

  assign rat.inst0_free_vld_o = free_vld_q[0];
  assign rat.inst1_free_vld_o = free_vld_q[1];
  assign rat.inst2_free_vld_o = free_vld_q[2];
  assign rat.inst3_free_vld_o = free_vld_q[3];
  assign rat.inst0_free_prd_o = free_prd_q[0];
  assign rat.inst1_free_prd_o = free_prd_q[1];
  assign rat.inst2_free_prd_o = free_prd_q[2];
  assign rat.inst3_free_prd_o = free_prd_q[3];
  assign rat.arch_rat_rec_o   = rec_q;
  assign rat.arch_stall_o     = stall_q;

  a_no_retire_in_recovery: assert property (@(posedge clock) disable iff (reset)
    (state_q != IDLE) |-> (we == 4'b0000));
endmodule

// File: tb/tb_arch_rat.sv
// Randomized + directed bench for arch_rat against a sequential in-order retire model.
module tb_arch_rat;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = 7;
  localparam int REC_HOLD = 1;
  localparam int MW       = NUM_AREG * PREG_W;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  arch_rat_if #(.NUM_AREG(NUM_AREG), .PREG_W(PREG_W)) rif ();

  arch_rat #(.NUM_AREG(NUM_AREG), .PREG_W(PREG_W), .REC_HOLD(REC_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .rat   (rif.slave)
  );

  logic [3:0]        f_vld;
  logic [PREG_W-1:0] f_prd [4];
  assign f_vld    = {rif.inst3_free_vld_o, rif.inst2_free_vld_o, rif.inst1_free_vld_o, rif.inst0_free_vld_o};
  assign f_prd[0] = rif.inst0_free_prd_o;
  assign f_prd[1] = rif.inst1_free_prd_o;
  assign f_prd[2] = rif.inst2_free_prd_o;
  assign f_prd[3] = rif.inst3_free_prd_o;

  // Reference state: committed map plus cycles of stall still owed after a flush.
  logic [PREG_W-1:0] ref_tbl [NUM_AREG];
  int                busy;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] ref_map();
    logic [MW-1:0] m;
    for (int i = 0; i < NUM_AREG; i++) m[i*PREG_W +: PREG_W] = ref_tbl[i];
    return m;
  endfunction

  task automatic drive(input logic [3:0] we, input logic [3:0][4:0] ard,
                       input logic [3:0][PREG_W-1:0] prd, input logic flush);
    rif.inst0_ret_we_i = we[0]; rif.inst0_ard_i = ard[0]; rif.inst0_prd_i = prd[0];
    rif.inst1_ret_we_i = we[1]; rif.inst1_ard_i = ard[1]; rif.inst1_prd_i = prd[1];
    rif.inst2_ret_we_i = we[2]; rif.inst2_ard_i = ard[2]; rif.inst2_prd_i = prd[2];
    rif.inst3_ret_we_i = we[3]; rif.inst3_ard_i = ard[3]; rif.inst3_prd_i = prd[3];
    rif.flush_req_i    = flush;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    drive('0, '0, '0, 1'b0);
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NUM_AREG; i++) ref_tbl[i] = PREG_W'(i);
    busy = 0;
    chk("rst_rec", 256'(rif.arch_rat_rec_o), 256'(0));
    chk("rst_stall", 256'(rif.arch_stall_o), 256'(0));
    chk("rst_free_vld", 256'(f_vld), 256'(0));
    for (int k = 0; k < 4; k++) chk($sformatf("rst_free_prd%0d", k), 256'(f_prd[k]), 256'(0));
    chk("rst_map", 256'(rif.arch_rat_rec_data_o), 256'(ref_map()));
  endtask

  // One cycle: drive at negedge, model in program order, check registered results next negedge.
  task automatic tick(input logic [3:0] we, input logic [3:0][4:0] ard,
                      input logic [3:0][PREG_W-1:0] prd, input logic flush);
    logic [3:0]        e_vld;
    logic [PREG_W-1:0] e_prd [4];
    logic              e_rec;
    e_vld = '0;
    e_rec = 1'b0;
    for (int k = 0; k < 4; k++) e_prd[k] = '0;
    drive(we, ard, prd, flush);
    if (busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k] && ard[k] != 5'd31) begin
          e_vld[k] = 1'b1;
          e_prd[k] = ref_tbl[ard[k]];
          ref_tbl[ard[k]] = prd[k];
        end
      end
      if (flush) begin
        e_rec = 1'b1;
        busy  = 1 + REC_HOLD;
      end
    end else begin
      busy--;
    end
    @(negedge clock);
    drive('0, '0, '0, 1'b0);
    chk("rec", 256'(rif.arch_rat_rec_o), 256'(e_rec));
    chk("stall", 256'(rif.arch_stall_o), 256'(busy != 0));
    chk("free_vld", 256'(f_vld), 256'(e_vld));
    for (int k = 0; k < 4; k++)
      if (e_vld[k]) chk($sformatf("free_prd%0d", k), 256'(f_prd[k]), 256'(e_prd[k]));
    chk("map", 256'(rif.arch_rat_rec_data_o), 256'(ref_map()));
  endtask

  initial begin
    logic [3:0]              rwe;
    logic [3:0][4:0]         rard;
    logic [3:0][PREG_W-1:0]  rprd;
    logic                    rfl;
    reset = 1'b1;
    drive('0, '0, '0, 1'b0);
    @(negedge clock);
    do_reset(2);

    tick(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd40}, 1'b0);
    chk("t2_free0", 256'(f_prd[0]), 256'(3));
    chk("t2_map3", 256'(rif.arch_rat_rec_data_o[3*7 +: 7]), 256'(40));

    tick(4'b1101, {5'd6, 5'd5, 5'd0, 5'd5}, {7'd35, 7'd34, 7'd0, 7'd33}, 1'b0);
    chk("t3_free0", 256'(f_prd[0]), 256'(5));
    chk("t3_free2", 256'(f_prd[2]), 256'(33));
    chk("t3_free3", 256'(f_prd[3]), 256'(6));
    chk("t3_map5", 256'(rif.arch_rat_rec_data_o[5*7 +: 7]), 256'(34));

    tick(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, {7'd0, 7'd0, 7'd50, 7'd0}, 1'b1);
    chk("t4_rec_map7", 256'(rif.arch_rat_rec_data_o[55:49]), 256'(50));
    chk("t4_rec_pulse", 256'(rif.arch_rat_rec_o), 256'(1));
    tick('0, '0, '0, 1'b0);
    tick('0, '0, '0, 1'b0);
    chk("t4_stall_off", 256'(rif.arch_stall_o), 256'(0));

    tick(4'b0001, {5'd0, 5'd0, 5'd0, 5'd31}, {7'd0, 7'd0, 7'd0, 7'd60}, 1'b0);
    chk("t5_map31", 256'(rif.arch_rat_rec_data_o[31*7 +: 7]), 256'(31));
    tick('0, '0, '0, 1'b1);
    tick('0, '0, '0, 1'b1);
    tick('0, '0, '0, 1'b1);
    chk("t5_no_second_rec", 256'(rif.arch_rat_rec_o), 256'(0));
    tick('0, '0, '0, 1'b0);

    tick(4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, {7'd0, 7'd0, 7'd0, 7'd70}, 1'b1);
    tick('0, '0, '0, 1'b0);
    do_reset(1);
    chk("t6_map2", 256'(rif.arch_rat_rec_data_o[2*7 +: 7]), 256'(2));
    tick('0, '0, '0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      rfl = ($urandom_range(0, 11) == 0);
      rwe = '0;
      rard = '0;
      rprd = '0;
      if (busy == 0) begin
        rwe = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
          rard[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
          if ($urandom_range(0, 15) == 0) rard[k] = 5'd31;
          rprd[k] = 7'($urandom);
        end
      end
      tick(rwe, rard, rprd, rfl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
